pll_lock_supervisor: RTL



---
 rtl/pll_lock_supervisor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds the PLL in reset, debounces lock, retries on timeout
// and sequences the downstream system reset. Runs on the PLL input clock.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter int LOCK_FILTER    = 256,
    parameter int RUN_DELAY      = 64,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       locked,
    output logic       lost_lock,
    output logic       fail,
    output logic [2:0] retry_count,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    // Counter value on the last cycle of each timed state.
    localparam logic [19:0] RST_LAST     = 20'(PLL_RST_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] FILTER_LAST  = 20'(LOCK_FILTER - 1);
    localparam logic [19:0] RUN_LAST     = 20'(RUN_DELAY - 1);
    localparam logic [2:0]  MAX_R        = 3'(MAX_RETRIES);

    state_t      state, state_next;
    logic [19:0] cnt, cnt_next;
    logic [2:0]  retry_next;
    logic        pll_reset_next, sys_reset_next, locked_next, lost_lock_next, fail_next;
    logic        lock_meta, lock_s;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_next     = state;
        retry_next     = retry_count;
        lost_lock_next = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle takes priority over the retry.
                if (lock_s) begin
                    state_next = ST_FILTER;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_count == MAX_R) begin
                        state_next = ST_FAIL;
                    end else begin
                        retry_next = retry_count + 3'd1;
                        state_next = ST_PLL_RST;
                    end
                end
            end
            ST_FILTER: begin
                if (!lock_s) state_next = ST_WAIT_LOCK;
                else if (cnt == FILTER_LAST) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_next     = ST_PLL_RST;
                    lost_lock_next = 1'b1;
                end else if (cnt == RUN_LAST) begin
                    state_next = ST_RUN;
                    retry_next = 3'd0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_next     = ST_PLL_RST;
                    lost_lock_next = 1'b1;
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_PLL_RST;
            end
        endcase

        cnt_next       = (state_next != state) ? 20'd0 : cnt + 20'd1;
        pll_reset_next = (state_next == ST_PLL_RST);
        sys_reset_next = (state_next != ST_RUN);
        locked_next    = (state_next == ST_HOLD) || (state_next == ST_RUN);
        fail_next      = (state_next == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_PLL_RST;
            cnt         <= 20'd0;
            retry_count <= 3'd0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            locked      <= 1'b0;
            lost_lock   <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            retry_count <= retry_next;
            pll_reset   <= pll_reset_next;
            sys_reset   <= sys_reset_next;
            locked      <= locked_next;
            lost_lock   <= lost_lock_next;
            fail        <= fail_next;
        end
    end

endmodule
